// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, types and state encoding for the memory arbiter slice
package mem_pkg;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 32;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant: first valid requester at or above ptr, wrapping modulo N
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  // Walk from the farthest offset to the nearest so the closest valid requester wins last.
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        winner = PW'((int'(ptr) + k) % N);
      end
    end
  end

  assign any = |valid;

  always_comb begin
    grant         = '0;
    grant[winner] = any;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter in front of a 1-cycle-latency RAM; MEM_ARB_INIT_EN adds a zero-fill INIT phase
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      init_done,
  output logic                      mem_wd_en,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  rd_owner;
  logic              rd_pend;
  logic [N_REQ-1:0]  valid_run;
  logic [N_REQ-1:0]  grant;
  logic              xfer;
  logic              xfer_we;
  logic              init_last;

`ifdef MEM_ARB_INIT_EN
  localparam arb_state_t RESET_STATE = INIT;

  logic [ADDR_W-1:0] init_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  assign init_last = &init_cnt;
`else
  localparam arb_state_t RESET_STATE = RUN;

  assign init_last = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Grants are masked while reset is held so the pins show their reset values throughout.
  assign valid_run = (state == RUN && !rst) ? req_valid : '0;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_rr (
    .valid  (valid_run),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (xfer)
  );

  assign req_ready = grant;
  assign xfer_we   = req_we[winner];

  always_comb begin
    mem_wd_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (xfer) begin
      mem_wd_en = xfer_we;
      mem_rd_en = ~xfer_we;
      mem_addr  = req_addr[winner*ADDR_W +: ADDR_W];
      mem_din   = req_wdata[winner*DATA_W +: DATA_W];
    end
`ifdef MEM_ARB_INIT_EN
    if (state == INIT && !rst) begin
      mem_wd_en = 1'b1;
      mem_addr  = init_cnt;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= '0;
    end else begin
      rd_pend <= xfer & ~xfer_we;
      if (xfer) begin
        rr_ptr <= PTR_W'(next_idx(int'(winner), N_REQ));
        if (!xfer_we) begin
          rd_owner <= winner;
        end
      end
    end
  end

  // RAM output is already registered, so read data passes straight through to the shared bus.
  always_comb begin
    rsp_valid = '0;
    if (rd_pend) begin
      rsp_valid[rd_owner] = 1'b1;
    end
  end

  assign rsp_rdata = mem_dout;
  assign init_done = (state == RUN);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares the single-port 32x32 distributed RAM between N_REQ requesters.
- Accepts at most one read or write per cycle, drives the RAM's write-enable, read-enable, address and data-in pins, and routes the 1-cycle-latency read data back to the issuing requester with a per-requester valid.
- Sits directly in front of the RAM instance; requesters never touch RAM pins.

Parameters:
- N_REQ, 2, number of requesters (legal 2..4).
- ADDR_W, 5, RAM address width (32 locations).
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  request present, one bit per requester.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  N_REQ*DATA_W  packed write data.
- req_ready  out  N_REQ  one-hot grant; transfer occurs when valid & ready.
- rsp_valid  out  N_REQ  read data valid for requester i.
- rsp_rdata  out  DATA_W  shared read data bus.
- init_done  out  1  high once the block accepts requests.
- mem_wd_en  out  1  to RAM wd_en.
- mem_rd_en  out  1  to RAM rd_en.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_din  out  DATA_W  to RAM din.
- mem_dout  in  DATA_W  from RAM dout (registered, 1-cycle latency).

Behaviour:
- FSM states: INIT, RUN. Reset enters INIT when MEM_ARB_INIT_EN is defined, else RUN.
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, mem_wd_en=0, mem_rd_en=0, mem_addr=0, mem_din=0.
  - Internals: rr_ptr=0, rd_pend=0, rd_owner=0.
  - init_done=0 in INIT, 1 in RUN.
- Arbitration in RUN:
  - req_ready is combinational from req_valid and rr_ptr.
  - Winner is the first requester with valid set, searching from rr_ptr upward and wrapping modulo N_REQ.
  - At most one ready bit is set; none when no valid is set.
  - req_ready must not depend on req_we or req_addr.
- Pointer update: on a transfer, rr_ptr <= winner+1 (wrapping to 0 after N_REQ-1). With no transfer, rr_ptr holds.
- Issue path (combinational pass-through in the grant cycle):
  - mem_addr and mem_din come from the winner's slices.
  - mem_wd_en = transfer & req_we[winner].
  - mem_rd_en = transfer & ~req_we[winner].
- Read return:
  - On a read transfer in cycle T, rd_pend<=1 and rd_owner<=winner.
  - In cycle T+1, rsp_valid[rd_owner]=1 and rsp_rdata=mem_dout.
  - rsp_valid is a single-cycle pulse with no back-pressure; requesters must sample it.
  - rsp_rdata is don't-care when no rsp_valid bit is set.
- Throughput: one transfer per cycle sustained. Back-to-back reads give back-to-back rsp_valid pulses, possibly to different requesters.
- Read/write ordering:
  - Write at T then read of the same address at T+1 returns the new data.
  - Read and write cannot share a cycle.
- Requester holding valid while not granted: request stays pending with no starvation. Worst-case wait is N_REQ-1 grants.
- Address range: ADDR_W spans all 32 words, so there is no out-of-range case.
- Reset mid-operation: any pending response is dropped, rsp_valid is 0 at the next edge, and rr_ptr returns to 0.

Optional Feature:
- Macro: MEM_ARB_INIT_EN.
- Defined:
  - After reset the FSM is in INIT, with req_ready=0 and init_done=0.
  - A 5-bit init counter writes DATA_W'0 to addresses 0..31, one per cycle, with mem_wd_en=1.
  - After address 31 is written: state RUN, init_done=1 on the following cycle. Total 32 cycles of INIT.
- Not defined: INIT and the counter are absent; RUN and init_done=1 from reset release.

Decomposition:
- Shared package mem_pkg holds:
  - Constants MEM_ADDR_W=5, MEM_DATA_W=32, MEM_DEPTH=32.
  - Typedef mem_addr_t, mem_data_t.
  - State enum arb_state_t {INIT, RUN}.
- Natural sub-module: rr_arbiter (valid vector + pointer -> one-hot grant + winner index), reusable elsewhere.

Test Plan:
- Init: with MEM_ARB_INIT_EN defined, release rst -> exactly 32 mem_wd_en pulses, addresses 0..31, din=0. init_done rises on the cycle after address 31; no req_ready during INIT.
- Single write/read: req0 writes 0xDEADBEEF to addr 7 at T, reads addr 7 at T+1 -> rsp_valid[0] at T+2 with rsp_rdata=0xDEADBEEF; rsp_valid[1] stays 0.
- Contention: req0 and req1 valid every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1 starting at 0 after reset, 3 transfers each.
- Response routing: req1 reads addr 3 (holds 0x11) at T, req0 reads addr 4 (holds 0x22) at T+1 -> rsp_valid[1] with 0x11 at T+1, rsp_valid[0] with 0x22 at T+2.
- Reset mid-op: assert rst in the cycle after a read grant -> rsp_valid=0 immediately (async), and no response after release.
- Idle: all req_valid=0 for 10 cycles -> mem_wd_en=mem_rd_en=0, rr_ptr unchanged, no rsp_valid.
